// File: rtl/xillybus_wrapper_sdiv_pkg.sv
// Shared definitions for the sequential signed-by-unsigned divider.
package xillybus_wrapper_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DIN0_W = 30;
    localparam int unsigned DIN1_W = 15;
    localparam int unsigned DOUT_W = 30;
    localparam int unsigned REM_W  = DIN1_W + 1;
    localparam int unsigned ITER   = DIN0_W;

endpackage

// File: rtl/xillybus_wrapper_sdiv_seq_step.sv
// One restoring shift-subtract step: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module xillybus_wrapper_sdiv_seq_step
    import xillybus_wrapper_sdiv_pkg::*;
#(
    parameter int unsigned PW = DIN1_W + 1,
    parameter int unsigned DW = DIN1_W
) (
    input  logic [PW-1:0] part,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [PW-1:0] part_nxt,
    output logic          q
);

    logic [PW:0] shifted;
    logic [PW:0] div_ext;

    always_comb begin
        shifted  = {part, bit_in};
        div_ext  = (PW+1)'(divisor);
        q        = (shifted >= div_ext);
        // On a successful subtract the difference is below the divisor, so
        // dropping the top bit is lossless.
        part_nxt = q ? PW'(shifted - div_ext) : shifted[PW-1:0];
    end

endmodule

// File: rtl/xillybus_wrapper_sdiv_seq.sv
// Iterative signed-by-unsigned divider (C truncation semantics) behind an
// HLS-style ap_start/ap_done/ap_idle/ap_ready handshake.
module xillybus_wrapper_sdiv_seq
    import xillybus_wrapper_sdiv_pkg::*;
#(
    parameter int unsigned ID         = 1,
    parameter int unsigned din0_WIDTH = DIN0_W,
    parameter int unsigned din1_WIDTH = DIN1_W,
    parameter int unsigned dout_WIDTH = DOUT_W,
    parameter int unsigned rem_WIDTH  = REM_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [rem_WIDTH-1:0]  rem,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = $clog2(din0_WIDTH);
    localparam int unsigned PW    = din1_WIDTH + 1;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [din0_WIDTH-1:0] mag;
    logic [din1_WIDTH-1:0] divisor;
    logic [PW-1:0]         part, part_nxt;
    logic                  neg, dz, q_bit;

    assign ap_idle  = (state == IDLE);
    assign ap_ready = ap_start & ap_idle;
    assign ap_done  = (state == DONE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    xillybus_wrapper_sdiv_seq_step #(
        .PW (PW),
        .DW (din1_WIDTH)
    ) u_step (
        .part     (part),
        .bit_in   (mag[din0_WIDTH-1]),
        .divisor  (divisor),
        .part_nxt (part_nxt),
        .q        (q_bit)
    );

    // The magnitude register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB. |din0| is held in
    // din0_WIDTH unsigned bits, which already covers 2^(din0_WIDTH-1).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt         <= '0;
            mag         <= '0;
            divisor     <= '0;
            part        <= '0;
            neg         <= 1'b0;
            dz          <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        neg     <= din0[din0_WIDTH-1];
                        mag     <= din0[din0_WIDTH-1] ? -din0 : din0;
                        divisor <= din1;
                        dz      <= (din1 == '0);
                        part    <= '0;
                        cnt     <= CNT_W'(din0_WIDTH - 1);
                    end
                end
                CALC: begin
                    part <= part_nxt;
                    mag  <= {mag[din0_WIDTH-2:0], q_bit};
                    cnt  <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (dz) begin
                        dout        <= '1;
                        rem         <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        dout        <= dout_WIDTH'(neg ? -mag : mag);
                        rem         <= rem_WIDTH'(neg ? -part : part);
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xillybus_wrapper_sdiv_seq.sv
// Self-checking bench for xillybus_wrapper_sdiv_seq: vector table, scoreboard
// monitor, mid-operation reset and back-to-back throughput sequences.
module tb_xillybus_wrapper_sdiv_seq;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready, ap_idle, ap_done, div_by_zero;
    logic [29:0] din0 = '0;
    logic [14:0] din1 = '0;
    logic [29:0] dout;
    logic [15:0] rem;

    typedef struct {
        logic [29:0] a;
        logic [14:0] b;
        logic [29:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    vec_t sb [$];
    vec_t mon_e;
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    always #5 ap_clk = ~ap_clk;

    xillybus_wrapper_sdiv_seq #(
        .ID         (1),
        .din0_WIDTH (30),
        .din1_WIDTH (15),
        .dout_WIDTH (30),
        .rem_WIDTH  (16)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .din0        (din0),
        .din1        (din1),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // C-semantics reference using the simulator's truncating division.
    function automatic vec_t model(input logic [29:0] a, input logic [14:0] b);
        vec_t   v;
        longint sa, sd;
        v.a = a;
        v.b = b;
        if (b == '0) begin
            v.q  = '1;
            v.r  = '0;
            v.dz = 1'b1;
        end else begin
            sa   = longint'($signed(a));
            sd   = longint'(b);
            v.q  = 30'(sa / sd);
            v.r  = 16'(sa % sd);
            v.dz = 1'b0;
        end
        return v;
    endfunction

    // Scoreboard: every completed operation must match the oldest pending one.
    always @(negedge ap_clk) begin
        if (ap_done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("dout", 64'(dout), 64'(mon_e.q));
                check("rem", 64'(rem), 64'(mon_e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int n;
        @(negedge ap_clk);
        din0     = v.a;
        din1     = v.b;
        ap_start = 1'b1;
        #1;
        check("ap_ready", 64'(ap_ready), 1);
        sb.push_back(v);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0     = 30'($urandom);
        din1     = 15'($urandom);
        n = 0;
        while (ap_done !== 1'b1 && n < 40) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 31);
        repeat (2) @(posedge ap_clk);
        #1;
        check("dout_hold", 64'(dout), 64'(v.q));
    endtask

    initial begin
        int   last, ndone, npush, dc;
        logic pidle, pready, pdone, exp_idle;

        vecs[0] = '{30'd100,        15'd7,     30'd14,         16'd2,     1'b0};
        vecs[1] = '{30'h3FFFFF9C,   15'd7,     30'h3FFFFFF2,   16'hFFFE,  1'b0};
        vecs[2] = '{30'd100,        15'd7,     30'd14,         16'd2,     1'b0};
        vecs[3] = '{30'h20000000,   15'd1,     30'h20000000,   16'd0,     1'b0};
        vecs[4] = '{30'd536870911,  15'd32767, 30'd16384,      16'd16383, 1'b0};
        vecs[5] = '{30'd5,          15'd0,     30'h3FFFFFFF,   16'd0,     1'b1};
        vecs[6] = '{30'd9,          15'd3,     30'd3,          16'd0,     1'b0};
        vecs[7] = '{30'h3FFFFFF9,   15'd7,     30'h3FFFFFFF,   16'd0,     1'b0};
        vecs[8] = '{30'd6,          15'd7,     30'd0,          16'd6,     1'b0};
        vecs[9] = '{30'h3FFFFFFA,   15'd7,     30'd0,          16'hFFFA,  1'b0};

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_idle", 64'(ap_idle), 1);
        check("rst_done", 64'(ap_done), 0);
        check("rst_ready", 64'(ap_ready), 0);
        check("rst_dout", 64'(dout), 0);
        check("rst_rem", 64'(rem), 0);
        check("rst_dz", 64'(div_by_zero), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

        // Reset in the middle of a calculation discards it.
        @(negedge ap_clk);
        din0     = 30'd100;
        din1     = 15'd7;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (10) @(posedge ap_clk);
        #2;
        dc = done_cnt;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_dout", 64'(dout), 0);
        check("midrst_rem", 64'(rem), 0);
        check("midrst_dz", 64'(div_by_zero), 0);
        check("midrst_idle", 64'(ap_idle), 1);
        check("midrst_done", 64'(ap_done), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (40) @(posedge ap_clk);
        #1;
        check("midrst_no_done", 64'(done_cnt), 64'(dc));
        run_op(vecs[0]);

        // Back-to-back with ap_start held high, new operands after each accept.
        pidle = 1'b1; pready = 1'b0; pdone = 1'b0;
        last = -1; ndone = 0; npush = 0;
        @(negedge ap_clk);
        din0     = 30'($urandom);
        din1     = 15'($urandom);
        ap_start = 1'b1;
        for (int c = 0; c < 400 && ndone < 5; c++) begin
            if (c > 0) @(negedge ap_clk);
            #1;
            exp_idle = pdone | (pidle & ~pready);
            check("b2b_idle", 64'(ap_idle), 64'(exp_idle));
            if (ap_ready) begin
                sb.push_back(model(din0, din1));
                npush++;
            end
            if (ap_done) begin
                if (last >= 0) check("b2b_period", 64'(c - last), 33);
                last = c;
                ndone++;
            end
            pidle  = ap_idle;
            pready = ap_ready;
            pdone  = ap_done;
            @(posedge ap_clk);
            #1;
            if (pready) begin
                if (npush == 5) begin
                    ap_start = 1'b0;
                end else begin
                    din0 = 30'($urandom);
                    din1 = 15'($urandom_range(0, 32767));
                end
            end
        end
        check("b2b_count", 64'(ndone), 5);
        repeat (3) @(posedge ap_clk);
        check("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
